clk_div_multi: RTL

CLK_DIV_MULTI -- requirements
Module: clk_div_multi

---
 rtl/clk_div_multi.sv | 80 ++++++++
 1 files changed

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with double-buffered configuration.
// Each channel counts 0..div-1; clk_out/tick are registered from next-state values.
module clk_div_multi #(
  parameter int CH_N      = 4,
  parameter int CNT_W     = 25,
  parameter int RESET_DIV = 25000000
) (
  input  logic                                      clk_50mhz,
  input  logic                                      rst,
  input  logic [CH_N-1:0]                           en,
  input  logic                                      sync,
  input  logic                                      cfg_wr,
  input  logic [((CH_N > 1) ? $clog2(CH_N) : 1)-1:0] cfg_sel,
  input  logic [CNT_W-1:0]                          cfg_div,
  input  logic [CNT_W-1:0]                          cfg_high,
  output logic [CH_N-1:0]                           clk_out,
  output logic [CH_N-1:0]                           tick,
  output logic [CH_N-1:0]                           cfg_pend
);

  localparam logic [CNT_W-1:0] RST_DIV  = CNT_W'(RESET_DIV);
  localparam logic [CNT_W-1:0] RST_HIGH = CNT_W'(RESET_DIV / 2);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  for (genvar g = 0; g < CH_N; g++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d, high_q, high_d;
    logic [CNT_W-1:0] sdiv_q, sdiv_d, shigh_q, shigh_d;
    logic             run_q, run_d, pend_q, pend_d;
    logic             clk_q, clk_d, tick_q, tick_d;
    logic             wr_hit, wrap, apply;

    always_comb begin
      // Out-of-range selects never match any channel index, so they are dropped.
      wr_hit  = cfg_wr && (int'(cfg_sel) == g);
      wrap    = run_q && (cnt_q == div_q - ONE);
      // A stopped channel (div=0) has no period to protect, so it takes new config at once.
      apply   = pend_q && (!en[g] || sync || wrap || (div_q == '0));
      div_d   = apply ? sdiv_q : div_q;
      high_d  = apply ? shigh_q : high_q;
      sdiv_d  = wr_hit ? cfg_div : sdiv_q;
      shigh_d = wr_hit ? cfg_high : shigh_q;
      pend_d  = wr_hit || (pend_q && !apply);
      run_d   = en[g] && (div_d != '0);
      if (!run_d || !run_q || sync || wrap) cnt_d = '0;
      else                                   cnt_d = cnt_q + ONE;
      clk_d   = run_d && (cnt_d < high_d);
      tick_d  = run_d && (cnt_d == div_d - ONE);
    end

    always_ff @(posedge clk_50mhz or posedge rst) begin
      if (rst) begin
        cnt_q   <= '0;
        div_q   <= RST_DIV;
        high_q  <= RST_HIGH;
        sdiv_q  <= RST_DIV;
        shigh_q <= RST_HIGH;
        run_q   <= 1'b0;
        pend_q  <= 1'b0;
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        div_q   <= div_d;
        high_q  <= high_d;
        sdiv_q  <= sdiv_d;
        shigh_q <= shigh_d;
        run_q   <= run_d;
        pend_q  <= pend_d;
        clk_q   <= clk_d;
        tick_q  <= tick_d;
      end
    end

    assign clk_out[g]  = clk_q;
    assign tick[g]     = tick_q;
    assign cfg_pend[g] = pend_q;
  end

endmodule
